// File: rtl/bloom_pkg.sv
// Shared types for the bloom filter bitmap: request opcodes and clear-sequencer states.
package bloom_pkg;

    typedef enum logic {
        BLOOM_QUERY  = 1'b0,
        BLOOM_INSERT = 1'b1
    } bloom_op_e;

    typedef enum logic {
        BLOOM_IDLE  = 1'b0,
        BLOOM_CLEAR = 1'b1
    } bloom_state_e;

endpackage

// File: rtl/bloom_bitmap_if.sv
// Request/response/clear bundle for the bloom bitmap; master is the hash/lookup side.
interface bloom_bitmap_if #(
    parameter int BL_SIZE   = 256,
    parameter int HASH_SIZE = 8
);
    localparam int PW = $clog2(BL_SIZE) + 1;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_op;
    logic [HASH_SIZE-1:0] req_hash;
    logic                 clear;
    logic                 busy;
    logic                 resp_valid;
    logic                 resp_hit;
    logic [PW-1:0]        pop_cnt;

    modport master (
        output req_valid, req_op, req_hash, clear,
        input  req_ready, busy, resp_valid, resp_hit, pop_cnt
    );

    modport slave (
        input  req_valid, req_op, req_hash, clear,
        output req_ready, busy, resp_valid, resp_hit, pop_cnt
    );
endinterface

// File: rtl/bloom_bitmap.sv
// Bloom filter bitmap: single-bit query/insert with 1-cycle response, population count,
// and a word-per-cycle clear sequencer.
module bloom_bitmap
    import bloom_pkg::*;
#(
    parameter int BL_SIZE   = 256,
    parameter int HASH_SIZE = 8,
    parameter int WORD_W    = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_op_i,
    input  logic [HASH_SIZE-1:0]         req_hash_i,
    input  logic                         clear_i,
    output logic                         busy_o,
    output logic                         resp_valid_o,
    output logic                         resp_hit_o,
    output logic [$clog2(BL_SIZE):0]     pop_cnt_o
);

    localparam int IDX_W = $clog2(BL_SIZE);
    localparam int WORDS = BL_SIZE / WORD_W;
    localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int PW    = IDX_W + 1;

    bloom_state_e                   state;
    logic [WORDS-1:0][WORD_W-1:0]   mem;
    logic [WAW-1:0]                 clr_word;
    logic [PW-1:0]                  pop_cnt;
    logic                           resp_valid;
    logic                           resp_hit;

    logic [IDX_W-1:0]               idx;
    logic [WAW-1:0]                 word_sel;
    logic [BW-1:0]                  bit_sel;
    logic                           cur_bit;
    logic                           accept;
    logic                           is_insert;

    assign idx       = req_hash_i[IDX_W-1:0];
    assign word_sel  = WAW'(idx / WORD_W);
    assign bit_sel   = BW'(idx % WORD_W);
    assign cur_bit   = mem[word_sel][bit_sel];
    assign is_insert = (bloom_op_e'(req_op_i) == BLOOM_INSERT);

    // Ready is gated by reset so nothing is accepted while rst_ni is held low.
    assign req_ready_o = rst_ni && (state == BLOOM_IDLE) && !clear_i;
    assign accept      = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= BLOOM_IDLE;
            mem        <= '0;
            clr_word   <= '0;
            pop_cnt    <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
        end else begin
            resp_valid <= accept;
            resp_hit   <= accept && cur_bit;
            case (state)
                BLOOM_IDLE: begin
                    if (clear_i) begin
                        // Count is dropped on entry so it reads 0 for the whole sweep.
                        state    <= BLOOM_CLEAR;
                        clr_word <= '0;
                        pop_cnt  <= '0;
                    end else if (accept && is_insert) begin
                        mem[word_sel][bit_sel] <= 1'b1;
                        if (!cur_bit && pop_cnt != PW'(BL_SIZE))
                            pop_cnt <= pop_cnt + PW'(1);
                    end
                end
                BLOOM_CLEAR: begin
                    mem[clr_word] <= '0;
                    if (clr_word == WAW'(WORDS - 1)) begin
                        state    <= BLOOM_IDLE;
                        clr_word <= '0;
                    end else begin
                        clr_word <= clr_word + WAW'(1);
                    end
                end
                default: state <= BLOOM_IDLE;
            endcase
        end
    end

    assign busy_o       = (state == BLOOM_CLEAR);
    assign resp_valid_o = resp_valid;
    assign resp_hit_o   = resp_hit;
    assign pop_cnt_o    = pop_cnt;

endmodule

// File: doc/bloom_bitmap.md
BLOOM_BITMAP -- requirements
Module: bloom_bitmap

Interface
REQ-001 SHALL have parameter BL_SIZE, 256, filter bit count; power of two, 64..4096.
REQ-002 SHALL have parameter HASH_SIZE, 8, width of the incoming hash index; HASH_SIZE >= log2(BL_SIZE).
REQ-003 SHALL have parameter WORD_W, 32, storage word width; power of two dividing BL_SIZE.
REQ-004 SHALL have port clk_i  input  1  the single clock; all state is updated on the rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid_i  input  1  request present.
REQ-007 SHALL have port req_ready_o  output  1  request accepted this cycle when high with req_valid_i.
REQ-008 SHALL have port req_op_i  input  1  operation: 0 = QUERY, 1 = INSERT.
REQ-009 SHALL have port req_hash_i  input  HASH_SIZE  hash from the upstream hash stage.
REQ-010 SHALL have port clear_i  input  1  single-cycle pulse that starts a full bitmap clear.
REQ-011 SHALL have port busy_o  output  1  clear sequence in progress.
REQ-012 SHALL have port resp_valid_o  output  1  response strobe.
REQ-013 SHALL have port resp_hit_o  output  1  pre-operation value of the addressed bit.
REQ-014 SHALL have port pop_cnt_o  output  log2(BL_SIZE)+1  number of set bits.

Function
REQ-015 Bit index SHALL be req_hash_i[log2(BL_SIZE)-1:0]; upper hash bits are ignored.
REQ-016 Storage SHALL be BL_SIZE/WORD_W words of WORD_W bits; word = index / WORD_W, bit = index % WORD_W.
REQ-017 FSM SHALL have states IDLE and CLEAR; reset state is IDLE.
REQ-018 req_ready_o SHALL be high exactly when state is IDLE and clear_i is low.
REQ-019 An accepted request SHALL produce resp_valid_o high for exactly one cycle on the following cycle (latency 1), with resp_hit_o equal to the addressed bit before the operation.
REQ-020 An accepted INSERT SHALL set the addressed bit at the acceptance edge; a QUERY SHALL modify nothing.
REQ-021 pop_cnt_o SHALL increment by 1 on an INSERT to a clear bit and stay unchanged on an INSERT to a set bit; max value BL_SIZE, never wraps.
REQ-022 Back-to-back requests SHALL be accepted every cycle; a request in cycle N+1 SHALL see an INSERT accepted in cycle N (no read-before-write hazard).
REQ-023 clear_i in IDLE SHALL move to CLEAR at the next edge; clear_i in CLEAR SHALL be ignored.
REQ-024 clear_i and req_valid_i high together SHALL give priority to clear: request not accepted (ready low), no response.
REQ-025 CLEAR SHALL zero one word per cycle, word 0 upward, taking BL_SIZE/WORD_W cycles, then return to IDLE; busy_o high for exactly those cycles.
REQ-026 pop_cnt_o SHALL read 0 from the first CLEAR cycle onward.
REQ-027 resp_valid_o, resp_hit_o SHALL be registered outputs; resp_hit_o SHALL be 0 whenever resp_valid_o is low.

Reset
REQ-028 Reset assertion SHALL immediately force: all bitmap bits 0, state IDLE, clear word counter 0, busy_o 0, resp_valid_o 0, resp_hit_o 0, pop_cnt_o 0.
REQ-029 Reset mid-CLEAR SHALL abandon the sequence; after deassertion the block is IDLE and ready on the first edge.
REQ-030 No request SHALL be accepted while rst_ni is low.

Structure
REQ-031 Package bloom_pkg SHALL hold the op enum (BLOOM_QUERY, BLOOM_INSERT) and the state enum (BLOOM_IDLE, BLOOM_CLEAR).
REQ-032 Index/word-count widths SHALL be localparams derived via $clog2 inside the module.
REQ-033 No sub-module; the clear sequencer is inline. The upstream hash stage's output drives req_hash_i and its insert strobe, delayed one cycle, drives req_valid_i.

Verification (BL_SIZE=256, WORD_W=32, HASH_SIZE=8)
REQ-034 After reset, QUERY hash 0x5A -> next cycle resp_valid_o=1, resp_hit_o=0, pop_cnt_o=0.
REQ-035 INSERT 0x5A, then INSERT 0x5A, then QUERY 0x5A on consecutive cycles -> hits 0,1,1; pop_cnt_o=1.
REQ-036 INSERT 0x00, 0x1F, 0x20, 0xFF -> pop_cnt_o=4; QUERY 0x21 -> hit 0 (word-boundary check).
REQ-037 clear_i with req_valid_i high -> ready low that cycle, no response, busy_o high exactly 8 cycles, then QUERY 0xFF -> hit 0, pop_cnt_o=0.
REQ-038 Reset pulse at CLEAR cycle 3 -> busy_o 0 immediately; after release ready=1 on first edge, all queries hit 0.
